ffwr_rrarb: RTL and testbench
=============================

FFWR_RRARB -- requirements
Module: ffwr_rrarb

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters.
REQ-002 Parameter DATW, default 32, FIFO data width.
REQ-003 Parameter BLENW, default 4, burst-length field width.
REQ-004 Parameter FLUSHW, default 4, cycles fifoflush is held asserted.
REQ-005 Port clk  in  1  single clock; all logic clocked on rising edge.
REQ-006 Port rst_  in  1  reset, synchronous, active-low.
REQ-007 Port req  in  NREQ  per-requester burst request, level.
REQ-008 Port reqlen  in  NREQ*BLENW  per-requester burst length in words; 0 is treated as 1.
REQ-009 Port reqdat  in  NREQ*DATW  per-requester write data.
REQ-010 Port flushreq  in  1  flush request, one-cycle pulse.
REQ-011 Port fifofull  in  1  FIFO write-side full flag.
REQ-012 Port oflushwr  in  1  FIFO write-side flush-in-progress.
REQ-013 Port gnt  out  NREQ  one-hot burst owner, zero when idle.
REQ-014 Port dack  out  NREQ  per-requester word-accepted strobe.
REQ-015 Port fifowr  out  1  FIFO write strobe.
REQ-016 Port fifodat  out  DATW  FIFO write data.
REQ-017 Port fifoflush  out  1  FIFO flush request.
REQ-018 Port flushbusy  out  1  high while a flush sequence is in progress.

Function
REQ-019 FSM states: IDLE, XFER, FLUSH, FWAIT.
REQ-020 A flushreq pulse in any state sets a pending-flush flag, which is cleared on entry to FLUSH.
REQ-021 IDLE with pending flush shall go to FLUSH; flush has priority over req.
REQ-022 IDLE with no pending flush and any req high shall pick a winner round-robin, starting at the index after the last completed owner.
REQ-023 On a pick, the block shall register gnt as one-hot, load the word counter from the winner's reqlen (0 loads 1), and go to XFER; gnt rises the cycle after req is sampled.
REQ-024 In XFER: fifowr = ~fifofull, fifodat = reqdat of the owner, and dack = gnt & fifowr; these outputs are combinational from registered state and fifofull.
REQ-025 Each fifowr cycle shall decrement the counter; on the last word, next state is IDLE, gnt clears, and the last-owner pointer updates.
REQ-026 One idle bubble cycle shall follow every burst; back-to-back bursts are therefore spaced by one cycle.
REQ-027 While fifofull is high in XFER: no write, no dack, counter held, burst not abandoned.
REQ-028 A flushreq during XFER shall be deferred until the burst ends; the current burst is never truncated.
REQ-029 The owner's req, reqlen and reqdat drop during a burst shall be ignored; the length is latched at grant.
REQ-030 FLUSH shall hold fifoflush=1 for exactly FLUSHW cycles (counter), then go to FWAIT.
REQ-031 FWAIT shall hold fifoflush=0 and return to IDLE in the cycle after oflushwr is sampled low.
REQ-032 flushbusy = state is FLUSH or FWAIT.
REQ-033 fifowr, dack and gnt shall be 0 in IDLE, FLUSH and FWAIT.
REQ-034 When only one requester is active, it shall win every arbitration.

Reset
REQ-035 rst_ low at a clock edge shall force IDLE, gnt=0, counter=0, pending flush=0, flush counter=0, and last-owner=NREQ-1 (requester 0 highest priority first).
REQ-036 Under reset, all outputs shall be 0; reset mid-burst abandons the burst without further writes.

Structure
REQ-037 FSM state encodings and the BLENW/FLUSHW defaults shall live in the shared macro defines file.
REQ-038 The round-robin pick (req, last-owner in; one-hot winner out, combinational) shall be sub-module ffwr_rrpick.

Verification
REQ-039 req=4'b0001, reqlen0=3, fifofull=0 -> gnt=0001 one cycle later, 3 consecutive fifowr with reqdat0, return to IDLE.
REQ-040 req=4'b1111, all reqlen=1, held -> grant order 0,1,2,3,0, one word each, one-cycle gaps.
REQ-041 Burst reqlen=4 with fifofull high for 5 cycles after word 2 -> exactly 4 writes total, no dack while full.
REQ-042 flushreq during a 4-word burst -> burst completes, then fifoflush high exactly FLUSHW=4 cycles, flushbusy high until 1 cycle after oflushwr is low.
REQ-043 reqlen=0 -> exactly 1 word written.
REQ-044 rst_ low after word 1 of a 3-word burst -> no further fifowr, gnt=0, and the next arbitration starts at requester 0.

Source files
------------

// File: rtl/ffwr_rrarb_pkg.sv
// Shared definitions for the FIFO-write round-robin arbiter: FSM state
// encodings and default field widths used by the top level.
package ffwr_rrarb_pkg;

    // Default burst-length field width and flush-hold duration
    localparam int BLENW_DEF  = 4;
    localparam int FLUSHW_DEF = 4;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FWAIT = 2'd3
    } state_t;

endpackage

// File: rtl/ffwr_rrpick.sv
// Round-robin picker: scans requesters starting at the index after the
// last completed owner and returns the first active one as a one-hot
// vector plus its index. Purely combinational.
module ffwr_rrpick #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] win,
    output logic [IDXW-1:0] win_idx
);

    // Rotating priority scan; the last owner is visited last
    always_comb begin
        logic found;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/ffwr_rrarb.sv
// FIFO-write round-robin arbiter. Grants whole bursts to one requester at
// a time, streams its words into a FIFO while honouring the full flag, and
// sequences FIFO flushes between bursts.
module ffwr_rrarb
    import ffwr_rrarb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATW   = 32,
    parameter int BLENW  = BLENW_DEF,
    parameter int FLUSHW = FLUSHW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BLENW-1:0]   reqlen,
    input  logic [NREQ*DATW-1:0]    reqdat,
    input  logic                    flushreq,
    input  logic                    fifofull,
    input  logic                    oflushwr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         dack,
    output logic                    fifowr,
    output logic [DATW-1:0]         fifodat,
    output logic                    fifoflush,
    output logic                    flushbusy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FCW  = $clog2(FLUSHW + 1);

    state_t            state_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [IDXW-1:0]   own_reg;
    logic [IDXW-1:0]   last_reg;
    logic [BLENW-1:0]  cnt_reg;
    logic              pend_reg;
    logic [FCW-1:0]    fcnt_reg;

    logic [NREQ-1:0]   pick_win;
    logic [IDXW-1:0]   pick_idx;
    logic [BLENW-1:0]  pick_len;
    logic [BLENW-1:0]  load_len;
    logic              write_en;

    logic [BLENW-1:0]  len_arr [NREQ];
    logic [DATW-1:0]   dat_arr [NREQ];

    // Split the flattened per-requester buses into indexable lanes
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign len_arr[gi] = reqlen[gi*BLENW +: BLENW];
        assign dat_arr[gi] = reqdat[gi*DATW +: DATW];
    end

    ffwr_rrpick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .last    (last_reg),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    // A zero-length request still moves one word
    assign pick_len = len_arr[pick_idx];
    assign load_len = (pick_len == '0) ? BLENW'(1) : pick_len;

    // Datapath outputs follow registered state and fifofull; everything is
    // forced low while reset is asserted so an abandoned burst writes nothing
    assign write_en  = rst_ && (state_reg == ST_XFER) && !fifofull;
    assign fifowr    = write_en;
    assign gnt       = rst_ ? gnt_reg : '0;
    assign dack      = gnt_reg & {NREQ{write_en}};
    assign fifodat   = (rst_ && (state_reg == ST_XFER)) ? dat_arr[own_reg] : '0;
    assign fifoflush = rst_ && (state_reg == ST_FLUSH);
    assign flushbusy = rst_ && ((state_reg == ST_FLUSH) || (state_reg == ST_FWAIT));

    // Arbitration / burst / flush sequencing FSM
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            own_reg   <= '0;
            last_reg  <= IDXW'(NREQ - 1);
            cnt_reg   <= '0;
            pend_reg  <= 1'b0;
            fcnt_reg  <= '0;
        end else begin
            // Flush pulses are remembered until the FSM is free to act on them
            pend_reg <= pend_reg | flushreq;
            case (state_reg)
                ST_IDLE: begin
                    if (pend_reg) begin
                        state_reg <= ST_FLUSH;
                        fcnt_reg  <= '0;
                        pend_reg  <= flushreq;
                    end else if (|req) begin
                        state_reg <= ST_XFER;
                        gnt_reg   <= pick_win;
                        own_reg   <= pick_idx;
                        cnt_reg   <= load_len;
                    end
                end
                ST_XFER: begin
                    // Counter only moves on accepted words; full stalls the burst
                    if (!fifofull) begin
                        if (cnt_reg == BLENW'(1)) begin
                            state_reg <= ST_IDLE;
                            gnt_reg   <= '0;
                            last_reg  <= own_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg - BLENW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_reg == FCW'(FLUSHW - 1)) begin
                        state_reg <= ST_FWAIT;
                        fcnt_reg  <= '0;
                    end else begin
                        fcnt_reg <= fcnt_reg + FCW'(1);
                    end
                end
                ST_FWAIT: begin
                    if (!oflushwr) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffwr_rrarb.sv
// Self-checking bench for ffwr_rrarb: directed scenarios followed by random
// traffic, every cycle compared against a burst-level behavioural model.
module tb_ffwr_rrarb;

    localparam int NREQ   = 4;
    localparam int DATW   = 32;
    localparam int BLENW  = 4;
    localparam int FLUSHW = 4;

    localparam int P_IDLE  = 0;
    localparam int P_BURST = 1;
    localparam int P_FLUSH = 2;
    localparam int P_WAIT  = 3;

    logic                  clk;
    logic                  rst_;
    logic [NREQ-1:0]       req;
    logic [NREQ*BLENW-1:0] reqlen;
    logic [NREQ*DATW-1:0]  reqdat;
    logic                  flushreq;
    logic                  fifofull;
    logic                  oflushwr;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       dack;
    logic                  fifowr;
    logic [DATW-1:0]       fifodat;
    logic                  fifoflush;
    logic                  flushbusy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int m_phase;
    int m_owner;
    int m_left;
    int m_last;
    int m_pend;
    int m_flcyc;
    int m_words;

    ffwr_rrarb #(
        .NREQ   (NREQ),
        .DATW   (DATW),
        .BLENW  (BLENW),
        .FLUSHW (FLUSHW)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req       (req),
        .reqlen    (reqlen),
        .reqdat    (reqdat),
        .flushreq  (flushreq),
        .fifofull  (fifofull),
        .oflushwr  (oflushwr),
        .gnt       (gnt),
        .dack      (dack),
        .fifowr    (fifowr),
        .fifodat   (fifodat),
        .fifoflush (fifoflush),
        .flushbusy (flushbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_owner = -1;
        m_left  = 0;
        m_last  = NREQ - 1;
        m_pend  = 0;
        m_flcyc = 0;
        m_words = 0;
    endtask

    task automatic set_len(input int lane, input int v);
        reqlen[lane*BLENW +: BLENW] = BLENW'(v);
    endtask

    // One clock: compare outputs at negedge, advance model, release after posedge
    task automatic cycle();
        logic [NREQ-1:0] e_gnt;
        logic            e_wr;
        logic [DATW-1:0] e_dat;
        logic            e_fl;
        logic            e_busy;
        @(negedge clk);
        e_gnt  = '0;
        e_wr   = 1'b0;
        e_dat  = '0;
        e_fl   = 1'b0;
        e_busy = 1'b0;
        if (rst_) begin
            if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
            e_wr   = (m_phase == P_BURST) && !fifofull;
            if (e_wr) e_dat = reqdat[m_owner*DATW +: DATW];
            e_fl   = (m_phase == P_FLUSH);
            e_busy = (m_phase == P_FLUSH) || (m_phase == P_WAIT);
        end
        check_eq("gnt", 64'(gnt), 64'(e_gnt));
        check_eq("dack", 64'(dack), 64'(e_wr ? e_gnt : '0));
        check_eq("fifowr", 64'(fifowr), 64'(e_wr));
        if (e_wr) check_eq("fifodat", 64'(fifodat), 64'(e_dat));
        check_eq("fifoflush", 64'(fifoflush), 64'(e_fl));
        check_eq("flushbusy", 64'(flushbusy), 64'(e_busy));

        // Model advance using the inputs that the next rising edge samples
        if (!rst_) begin
            model_reset();
        end else begin
            int pend_in;
            pend_in = m_pend | int'(flushreq);
            case (m_phase)
                P_IDLE: begin
                    if (m_pend != 0) begin
                        m_phase = P_FLUSH;
                        m_flcyc = 0;
                        pend_in = int'(flushreq);
                    end else if (req != 0) begin
                        for (int k = 1; k <= NREQ; k++) begin
                            int i;
                            i = (m_last + k) % NREQ;
                            if (m_owner < 0 && req[i]) m_owner = i;
                        end
                        m_left  = int'(reqlen[m_owner*BLENW +: BLENW]);
                        if (m_left == 0) m_left = 1;
                        m_words = 0;
                        m_phase = P_BURST;
                    end
                end
                P_BURST: begin
                    if (!fifofull) begin
                        m_left--;
                        m_words++;
                        if (m_left == 0) begin
                            $display("burst owner=%0d words=%0d cyc=%0d", m_owner, m_words, cyc);
                            m_last  = m_owner;
                            m_owner = -1;
                            m_phase = P_IDLE;
                        end
                    end
                end
                P_FLUSH: begin
                    m_flcyc++;
                    if (m_flcyc == FLUSHW) m_phase = P_WAIT;
                end
                default: begin
                    if (!oflushwr) begin
                        $display("flush done cyc=%0d", cyc);
                        m_phase = P_IDLE;
                    end
                end
            endcase
            m_pend = pend_in;
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < NREQ; j++) reqdat[j*DATW +: DATW] = $urandom;
    endtask

    initial begin
        rst_     = 1'b0;
        req      = '0;
        reqlen   = '0;
        reqdat   = '0;
        flushreq = 1'b0;
        fifofull = 1'b0;
        oflushwr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        rst_ = 1'b1;
        cycle();

        // Single requester, three-word burst
        req = 4'b0001;
        set_len(0, 3);
        repeat (4) cycle();
        req = '0;
        repeat (3) cycle();

        // All requesters, one word each, rotating grants
        for (int j = 0; j < NREQ; j++) set_len(j, 1);
        req = 4'b1111;
        repeat (12) cycle();
        req = '0;
        cycle();

        // Four-word burst stalled by fifofull after the second word
        req = 4'b0010;
        set_len(1, 4);
        repeat (3) cycle();
        req = '0;
        fifofull = 1'b1;
        repeat (5) cycle();
        fifofull = 1'b0;
        repeat (4) cycle();

        // Flush requested mid-burst
        oflushwr = 1'b1;
        req = 4'b0100;
        set_len(2, 4);
        repeat (2) cycle();
        flushreq = 1'b1;
        cycle();
        flushreq = 1'b0;
        req = '0;
        repeat (10) cycle();
        oflushwr = 1'b0;
        repeat (3) cycle();

        // Zero length moves exactly one word
        req = 4'b1000;
        set_len(3, 0);
        repeat (2) cycle();
        req = '0;
        repeat (2) cycle();

        // Reset after first word of a three-word burst
        req = 4'b0100;
        set_len(2, 3);
        repeat (2) cycle();
        rst_ = 1'b0;
        cycle();
        rst_ = 1'b1;
        for (int j = 0; j < NREQ; j++) set_len(j, 1);
        req = 4'b1111;
        repeat (4) cycle();
        req = '0;
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_     = ($urandom_range(0, 299) != 0);
            for (int j = 0; j < NREQ; j++) begin
                req[j] = ($urandom_range(0, 9) < 4);
                set_len(j, int'($urandom_range(0, 5)));
            end
            fifofull = ($urandom_range(0, 3) == 0);
            flushreq = ($urandom_range(0, 39) == 0);
            oflushwr = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
